// File: rtl/ex_pkg.sv
// Shared constants, ALU opcodes, FSM encoding and EX/MEM bundle for the execute stage.
// EX_ITER_DIV_EN: when defined, op 9 (DIV) is an iterative operation; otherwise it is an undefined code.
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 8;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 5;

    localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 5'd4;
    localparam logic [OP_W-1:0] ALU_SLT = 5'd5;
    localparam logic [OP_W-1:0] ALU_SLL = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRL = 5'd7;
    localparam logic [OP_W-1:0] ALU_MUL = 5'd8;
    localparam logic [OP_W-1:0] ALU_DIV = 5'd9;
    localparam logic [OP_W-1:0] ALU_NOP = 5'b11111;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } iter_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [4:0]        rd;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch_taken;
        logic [PC_W-1:0]   branch_tgt;
    } exmem_t;

    function automatic logic is_single_op(input logic [OP_W-1:0] op);
        return (op <= ALU_SRL);
    endfunction

    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
`ifdef EX_ITER_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIV);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/ex_iter_muldiv.sv
// Iterative radix-2 unit: shift-add multiply or restoring divide, one step per clock, 32 steps.
// The last step is combinational so the top can capture the final value on the leaving edge.
module ex_iter_muldiv
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output iter_state_e       state_o,
    output logic              last_o,
    output logic [DATA_W-1:0] result_o
);

    iter_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              div_q, div_d;

    logic [DATA_W-1:0] step_acc, step_a, step_b;
    logic [DATA_W:0]   rem_sh;

    // MUL: acc=product, opa=shifted multiplicand, opb=multiplier.
    // DIV: acc=remainder, opa=dividend shifting out / quotient shifting in, opb=divisor.
    always_comb begin
        rem_sh   = {acc_q, opa_q[DATA_W-1]};
        step_acc = acc_q;
        step_a   = opa_q;
        step_b   = opb_q;
        if (div_q) begin
            if (rem_sh >= {1'b0, opb_q}) begin
                step_acc = DATA_W'(rem_sh - {1'b0, opb_q});
                step_a   = {opa_q[DATA_W-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[DATA_W-1:0];
                step_a   = {opa_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            step_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
            step_a   = {opa_q[DATA_W-2:0], 1'b0};
            step_b   = {1'b0, opb_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opa_d   = a_i;
                    opb_d   = b_i;
                    div_d   = div_i;
                end
            end
            ST_BUSY: begin
                acc_d = step_acc;
                opa_d = step_a;
                opb_d = step_b;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_o  = state_q;
        last_o   = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
        result_o = div_q ? step_a : step_acc;
    end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand-B mux, single-cycle ALU, branch resolve, EX/MEM register and stall for MUL/DIV.
// EX_ITER_DIV_EN: when defined, op 9 runs unsigned restoring division through the iterative unit.
module ex_stage_unit
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   inPc,
    input  logic [DATA_W-1:0] inReadData1,
    input  logic [DATA_W-1:0] inReadData2,
    input  logic [DATA_W-1:0] inSignExtImm,
    input  logic [4:0]        inRd,
    input  logic              inALUSrc,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inBranch,
    input  logic [OP_W-1:0]   inALUOp,
    output logic [DATA_W-1:0] outAluResult,
    output logic [DATA_W-1:0] outWriteData,
    output logic [4:0]        outRd,
    output logic              outMemToReg,
    output logic              outRegWrite,
    output logic              outMemRead,
    output logic              outMemWrite,
    output logic              outBranchTaken,
    output logic [PC_W-1:0]   outBranchTgt,
    output logic              stall
);

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] iter_res;
    logic              iter_op, div_sel, busy, iter_last, iter_start, cap_valid;
    iter_state_e       iter_state;
    exmem_t            exmem_q, exmem_d;

    assign op_b = inALUSrc ? inSignExtImm : inReadData2;

    always_comb begin
        alu_res = '0;
        case (inALUOp)
            ALU_ADD: alu_res = inReadData1 + op_b;
            ALU_SUB: alu_res = inReadData1 - op_b;
            ALU_AND: alu_res = inReadData1 & op_b;
            ALU_OR:  alu_res = inReadData1 | op_b;
            ALU_XOR: alu_res = inReadData1 ^ op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(inReadData1) < $signed(op_b))};
            ALU_SLL: alu_res = inReadData1 << op_b[4:0];
            ALU_SRL: alu_res = inReadData1 >> op_b[4:0];
            default: alu_res = '0;
        endcase
    end

`ifdef EX_ITER_DIV_EN
    assign div_sel = (inALUOp == ALU_DIV);
`else
    assign div_sel = 1'b0;
`endif

    assign iter_op    = is_iter_op(inALUOp);
    assign busy       = (iter_state == ST_BUSY);
    assign iter_start = rst & iter_op & ~busy;
    // Reset gates stall so a held MUL on the inputs cannot stall a core that is in reset.
    assign stall      = rst & ((iter_op & ~busy) | (busy & ~iter_last));

    ex_iter_muldiv u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (iter_start),
        .div_i    (div_sel),
        .a_i      (inReadData1),
        .b_i      (op_b),
        .state_o  (iter_state),
        .last_o   (iter_last),
        .result_o (iter_res)
    );

    // While busy only the final step captures; the start cycle and all other cycles are bubbles.
    assign cap_valid = busy ? iter_last : is_single_op(inALUOp);

    always_comb begin
        exmem_d = '0;
        if (cap_valid) begin
            exmem_d.alu_result   = busy ? iter_res : alu_res;
            exmem_d.write_data   = inReadData2;
            exmem_d.rd           = inRd;
            exmem_d.mem_to_reg   = inMemToReg;
            exmem_d.reg_write    = inRegWrite;
            exmem_d.mem_read     = inMemRead;
            exmem_d.mem_write    = inMemWrite;
            exmem_d.branch_taken = inBranch & (inReadData1 == inReadData2);
            exmem_d.branch_tgt   = inPc + inSignExtImm[PC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign outAluResult   = exmem_q.alu_result;
    assign outWriteData   = exmem_q.write_data;
    assign outRd          = exmem_q.rd;
    assign outMemToReg    = exmem_q.mem_to_reg;
    assign outRegWrite    = exmem_q.reg_write;
    assign outMemRead     = exmem_q.mem_read;
    assign outMemWrite    = exmem_q.mem_write;
    assign outBranchTaken = exmem_q.branch_taken;
    assign outBranchTgt   = exmem_q.branch_tgt;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: hand vectors, iterative-op sequences, reset abort and random ops vs a reference model.
module tb_ex_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inPc;
    logic [31:0] inReadData1, inReadData2, inSignExtImm;
    logic [4:0]  inRd;
    logic        inALUSrc, inMemToReg, inRegWrite, inMemRead, inMemWrite, inBranch;
    logic [4:0]  inALUOp;
    logic [31:0] outAluResult, outWriteData;
    logic [4:0]  outRd;
    logic        outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken;
    logic [7:0]  outBranchTgt;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, rd2, imm;
        logic        src, br;
        logic [7:0]  pc;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic [31:0] exp_res;
        logic        exp_taken;
        logic [7:0]  exp_tgt;
        logic        exp_valid;
    } vec_t;

    ex_stage_unit dut (
        .clk(clk), .rst(rst), .inPc(inPc), .inReadData1(inReadData1), .inReadData2(inReadData2),
        .inSignExtImm(inSignExtImm), .inRd(inRd), .inALUSrc(inALUSrc), .inMemToReg(inMemToReg),
        .inRegWrite(inRegWrite), .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inBranch(inBranch),
        .inALUOp(inALUOp), .outAluResult(outAluResult), .outWriteData(outWriteData), .outRd(outRd),
        .outMemToReg(outMemToReg), .outRegWrite(outRegWrite), .outMemRead(outMemRead),
        .outMemWrite(outMemWrite), .outBranchTaken(outBranchTaken), .outBranchTgt(outBranchTgt),
        .stall(stall)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic src, input logic [7:0] pc,
                                input logic br, input logic [3:0] ctrl, input logic [31:0] er,
                                input logic et, input logic [7:0] etg, input logic ev);
        vec_t v;
        v.op = op; v.a = a; v.rd2 = rd2; v.imm = imm; v.src = src; v.pc = pc; v.br = br;
        v.rd = 5'd3; v.ctrl = ctrl; v.exp_res = er; v.exp_taken = et; v.exp_tgt = etg; v.exp_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inALUOp = v.op; inReadData1 = v.a; inReadData2 = v.rd2; inSignExtImm = v.imm;
        inALUSrc = v.src; inPc = v.pc; inBranch = v.br; inRd = v.rd;
        {inMemToReg, inRegWrite, inMemRead, inMemWrite} = v.ctrl;
    endtask

    task automatic drive_nop();
        vec_t v;
        v = mk(5'd31, 32'd0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b0, 4'd0, 32'd0, 1'b0, 8'd0, 1'b0);
        drive(v);
    endtask

    task automatic check_out(input string name, input vec_t v);
        if (v.exp_valid) begin
            chk({name, ".res"},   outAluResult, v.exp_res);
            chk({name, ".wdata"}, outWriteData, v.rd2);
            chk({name, ".rd"},    {27'd0, outRd}, {27'd0, v.rd});
            chk({name, ".ctrl"},  {28'd0, outMemToReg, outRegWrite, outMemRead, outMemWrite}, {28'd0, v.ctrl});
            chk({name, ".taken"}, {31'd0, outBranchTaken}, {31'd0, v.exp_taken});
            chk({name, ".tgt"},   {24'd0, outBranchTgt}, {24'd0, v.exp_tgt});
        end else begin
            chk({name, ".bubble"}, {outAluResult, outWriteData, outRd, outMemToReg, outRegWrite,
                 outMemRead, outMemWrite, outBranchTaken, outBranchTgt} == '0 ? 32'd0 : 32'd1, 32'd0);
        end
    endtask

    // Reference model: straight arithmetic on the architectural rules.
    function automatic logic model_valid(input logic [4:0] op);
`ifdef EX_ITER_DIV_EN
        return op <= 5'd9;
`else
        return op <= 5'd8;
`endif
    endfunction

    function automatic logic model_iter(input logic [4:0] op);
        return (op == 5'd8) || (op == 5'd9 && model_valid(op));
    endfunction

    function automatic vec_t model(input vec_t v);
        logic [31:0] b;
        vec_t r;
        r = v;
        b = v.src ? v.imm : v.rd2;
        case (v.op)
            5'd0: r.exp_res = v.a + b;
            5'd1: r.exp_res = v.a - b;
            5'd2: r.exp_res = v.a & b;
            5'd3: r.exp_res = v.a | b;
            5'd4: r.exp_res = v.a ^ b;
            5'd5: r.exp_res = ($signed(v.a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd6: r.exp_res = v.a << b[4:0];
            5'd7: r.exp_res = v.a >> b[4:0];
            5'd8: r.exp_res = v.a * b;
            5'd9: r.exp_res = (b == 0) ? 32'hFFFF_FFFF : v.a / b;
            default: r.exp_res = 32'd0;
        endcase
        r.exp_valid = model_valid(v.op);
        r.exp_taken = v.br && (v.a == v.rd2);
        r.exp_tgt   = v.pc + v.imm[7:0];
        return r;
    endfunction

    // ---------------- driver sequences ----------------
    task automatic run_single(input string name, input vec_t v);
        logic [31:0] e;
        drive(v);
        exp_q.push_back(v.exp_res);
        #1;
        chk({name, ".stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        if (v.exp_valid) chk({name, ".sb"}, outAluResult, e);
        check_out(name, v);
    endtask

    task automatic run_iter(input string name, input vec_t v);
        int n;
        bit bad;
        n = 0; bad = 0;
        drive(v);
        #1;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (outRegWrite !== 1'b0 || outAluResult !== 32'd0) bad = 1;
        end
        chk({name, ".stall_cycles"}, n, 32'd32);
        chk({name, ".bubble_while_stalled"}, {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        check_out(name, v);
        drive_nop();
        @(posedge clk); #1;
        chk({name, ".regwrite_once"}, {31'd0, outRegWrite}, 32'd0);
    endtask

    // ---------------- main test ----------------
    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [4:0] ops[12];

        rst = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        v = mk(5'd31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("reset", v);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        // op, a, rd2, imm, src, pc, br, ctrl, exp_res, exp_taken, exp_tgt, valid
        vecs.push_back(mk(5'd0, 32'd5, 32'h55, 32'hFFFF_FFFD, 1, 8'h20, 0, 4'b0100, 32'd2, 0, 8'h1D, 1));
        vecs.push_back(mk(5'd1, 32'd3, 32'd5, 32'd0, 0, 8'h40, 0, 4'b0100, 32'hFFFF_FFFE, 0, 8'h40, 1));
        vecs.push_back(mk(5'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd2, 0, 8'h41, 0, 4'b1110, 32'h00F0_00F0, 0, 8'h43, 1));
        vecs.push_back(mk(5'd3, 32'h1200_0000, 32'hABCD, 32'h34, 1, 8'h50, 0, 4'b0001, 32'h1200_0034, 0, 8'h84, 1));
        vecs.push_back(mk(5'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd1, 0, 8'hFF, 0, 4'b0100, 32'hF0F0_0F0F, 0, 8'h00, 1));
        vecs.push_back(mk(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 8'h00, 0, 4'b0100, 32'd1, 0, 8'h00, 1));
        vecs.push_back(mk(5'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 8'h00, 0, 4'b0100, 32'd0, 0, 8'h00, 1));
        vecs.push_back(mk(5'd6, 32'd1, 32'h3F, 32'd0, 0, 8'h00, 0, 4'b0100, 32'h8000_0000, 0, 8'h00, 1));
        vecs.push_back(mk(5'd7, 32'h8000_0000, 32'd9, 32'd4, 1, 8'h00, 0, 4'b0100, 32'h0800_0000, 0, 8'h04, 1));
        vecs.push_back(mk(5'd1, 32'd9, 32'd9, 32'hFFFF_FFFC, 0, 8'h10, 1, 4'b0000, 32'd0, 1, 8'h0C, 1));
        vecs.push_back(mk(5'd1, 32'd9, 32'd8, 32'hFFFF_FFFC, 0, 8'h10, 1, 4'b0000, 32'd1, 0, 8'h0C, 1));
        vecs.push_back(mk(5'd31, 32'd7, 32'd7, 32'd1, 0, 8'h10, 1, 4'b0100, 32'd0, 0, 8'h00, 0));
        vecs.push_back(mk(5'd12, 32'd7, 32'd7, 32'd1, 0, 8'h10, 1, 4'b0100, 32'd0, 0, 8'h00, 0));
`ifndef EX_ITER_DIV_EN
        vecs.push_back(mk(5'd9, 32'd100, 32'd7, 32'd0, 0, 8'h10, 0, 4'b0100, 32'd0, 0, 8'h00, 0));
`endif
        foreach (vecs[i]) run_single($sformatf("vec%0d", i), vecs[i]);

        // Iterative sequences
        run_iter("mul_trunc", mk(5'd8, 32'h0001_0000, 32'h0001_0000, 32'd0, 0, 8'h00, 0, 4'b0100, 32'd0, 0, 8'h00, 1));
        run_iter("mul_imm", mk(5'd8, 32'd123456, 32'd0, 32'hFFFF_FFFF, 1, 8'h22, 0, 4'b0100, 32'hFFFE_1DC0, 0, 8'h21, 1));
`ifdef EX_ITER_DIV_EN
        run_iter("div_100_7", mk(5'd9, 32'd100, 32'd7, 32'd0, 0, 8'h00, 0, 4'b0100, 32'd14, 0, 8'h00, 1));
        run_iter("div_by_0", mk(5'd9, 32'd55, 32'd0, 32'd0, 0, 8'h00, 0, 4'b0100, 32'hFFFF_FFFF, 0, 8'h00, 1));
`endif

        // Reset while the multiplier is at cnt=10
        drive(mk(5'd8, 32'h1234, 32'h5678, 32'd0, 0, 8'h00, 0, 4'b0100, 0, 0, 0, 1));
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid.stall", {31'd0, stall}, 32'd0);
        check_out("rst_mid", mk(5'd31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("rst_mid.stall_held", {31'd0, stall}, 32'd0);
        rst = 1'b1;
        run_iter("mul_7x6", mk(5'd8, 32'd7, 32'd6, 32'd0, 0, 8'h00, 0, 4'b0100, 32'd42, 0, 8'h00, 1));

        // Random stream against the reference model
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd12, 5'd31};
        for (int i = 0; i < 150; i++) begin
            v.op   = ops[$urandom_range(0, 11)];
            if (model_iter(v.op) && $urandom_range(0, 2) != 0) v.op = 5'd0;
            v.a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            v.rd2  = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
            v.imm  = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
            v.src  = 1'($urandom);
            v.pc   = 8'($urandom);
            v.br   = 1'($urandom);
            v.rd   = 5'($urandom);
            v.ctrl = 4'($urandom);
            v = model(v);
            if (model_iter(v.op)) run_iter($sformatf("rnd%0d_iter", i), v);
            else                  run_single($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
